aes_iter_data_path: RTL and testbench
=====================================

Name: aes_iter_data_path

Overview:
Iterative AES encryption datapath. It runs one round per clock through a single shared round function, supports AES-128/192/256 (10/12/14 rounds) selected per block, and uses valid/ready handshakes on input and output. It is the successor to the unrolled fixed-10-round datapath and sits between the GCM counter-block generator (upstream) and the GHASH/XOR stage (downstream). Round keys come from the external key-expansion store, addressed by round index.

Parameters:
RND_SIZE, 128, block/state width in bits; fixed at 128 for AES.
CNT_SIZE, 4, round index width; must hold 0..14.
TAG_W, 8, sideband tag width (GCM stream/channel ID), carried through unmodified.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
i_key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128; sampled at accept.
i_in_valid  input  1  input block valid.
o_in_ready  output  1  datapath can accept a block this cycle.
i_rnd_text  input  RND_SIZE  plaintext/counter block.
i_tag  input  TAG_W  sideband tag, sampled at accept.
o_rk_idx  output  CNT_SIZE  round-key index requested this cycle.
i_rnd_key  input  RND_SIZE  round key for o_rk_idx, combinational, same cycle.
o_out_valid  output  1  o_cypher_text valid.
i_out_ready  input  1  downstream accepts output.
o_cypher_text  output  RND_SIZE  ciphertext; held stable while o_out_valid=1.
o_tag  output  TAG_W  tag of the block on o_cypher_text.
o_busy  output  1  high in RUN or DONE.

Behaviour:
- State machine IDLE, RUN, DONE. Accept = i_in_valid & o_in_ready.
- o_in_ready = (state==IDLE) | (state==DONE & i_out_ready).
- Reset (rst=1 at an edge): state=IDLE, round counter=0, state register=0, o_cypher_text=0, o_tag=0, o_out_valid=0, o_busy=0, o_rk_idx=0, latched Nr=10. Reset mid-block discards the block silently and emits no output.
- o_rk_idx = 0 in IDLE and DONE; equals the round counter in RUN.
- On accept: state_reg <= i_rnd_text ^ i_rnd_key (rk0); latch Nr (10/12/14) and tag; counter <= 1; go to RUN.
- RUN, counter r: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), i_rnd_key). When r==Nr, MixColumns is skipped (last round). If r<Nr, counter increments. If r==Nr, go to DONE with o_out_valid=1.
- Latency: o_out_valid rises exactly Nr cycles after the accept edge (10/12/14). Throughput is one block per Nr+1 cycles when i_out_ready is held high.
- DONE: o_cypher_text/o_tag hold until i_out_ready=1.
  - i_out_ready=1 and accept in the same cycle: output retires and the new block loads (back-to-back); go to RUN, o_out_valid=0 next cycle.
  - i_out_ready=1 without accept: go to IDLE.
- i_key_len, i_rnd_text, i_tag are ignored except at accept. A change to i_key_len during RUN has no effect.
- Byte order follows FIPS-197: bits [127:120] = byte 0, and the state is column-major.
- SubBytes uses a combinational S-box (16 instances). xtime uses the polynomial 0x11B.

Test Plan:
- AES-128, FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, bench supplies the expanded keys by o_rk_idx -> o_out_valid 10 cycles after accept, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192 C.2 (key 000102…17) and AES-256 C.3 (key 000102…1f), same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles; ct 8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- Backpressure: hold i_out_ready=0 for 20 cycles after valid -> o_out_valid, ct and o_tag stable; o_in_ready=0; no new accept. Raise i_out_ready -> single retirement.
- Back-to-back: 4 blocks, i_in_valid and i_out_ready always 1, key_len=0, tags 1..4 -> each output 11 cycles apart, correct ct per tag, no gaps beyond Nr+1.
- Reset mid-operation: assert rst at round 5 for 1 cycle -> next cycle o_out_valid=0, o_busy=0, o_in_ready=1; the aborted block is never output; the following block encrypts correctly.
- key_len=3 -> behaves as AES-128 (10 cycles, C.1 ct). key_len changed mid-RUN -> no effect on the result.

Source files
------------

// File: rtl/aes_iter_data_path.sv
`default_nettype none
// ============================================================================
// Module   : aes_iter_data_path
// Brief    : Iterative AES-128/192/256 encryption datapath, one round per clock
//            through a shared round function, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module aes_iter_data_path #(
    parameter int RND_SIZE = 128,
    parameter int CNT_SIZE = 4,
    parameter int TAG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_key_len,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [RND_SIZE-1:0] i_rnd_text,
    input  logic [TAG_W-1:0]    i_tag,
    output logic [CNT_SIZE-1:0] o_rk_idx,
    input  logic [RND_SIZE-1:0] i_rnd_key,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [RND_SIZE-1:0] o_cypher_text,
    output logic [TAG_W-1:0]    o_tag,
    output logic                o_busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam int         c_nbytes  = RND_SIZE / 8;
    localparam int         c_ncols   = c_nbytes / 4;

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = f_gmul(p, p);
            r = f_gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [CNT_SIZE-1:0] r_cnt;
    logic [CNT_SIZE-1:0] r_nr;
    logic [CNT_SIZE-1:0] w_nr;
    logic [RND_SIZE-1:0] r_data;
    logic [TAG_W-1:0]    r_tag;
    logic [RND_SIZE-1:0] w_sub;
    logic [RND_SIZE-1:0] w_shift;
    logic [RND_SIZE-1:0] w_mix;
    logic [RND_SIZE-1:0] w_round;
    logic                w_accept;
    logic                w_last;

    genvar gi, gc, gr;

    generate
        for (gi = 0; gi < c_nbytes; gi++) begin : g_sbox
            assign w_sub[RND_SIZE-1-8*gi -: 8] = f_sbox(r_data[RND_SIZE-1-8*gi -: 8]);
        end

        // Column-major state: byte 4c+r sits at row r, column c
        for (gc = 0; gc < c_ncols; gc++) begin : g_shift_col
            for (gr = 0; gr < 4; gr++) begin : g_shift_row
                assign w_shift[RND_SIZE-1-8*(4*gc+gr) -: 8] =
                    w_sub[RND_SIZE-1-8*(4*((gc+gr)%c_ncols)+gr) -: 8];
            end
        end

        for (gc = 0; gc < c_ncols; gc++) begin : g_mix
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_shift[RND_SIZE-1-32*gc  -: 8];
            assign w_a1 = w_shift[RND_SIZE-9-32*gc  -: 8];
            assign w_a2 = w_shift[RND_SIZE-17-32*gc -: 8];
            assign w_a3 = w_shift[RND_SIZE-25-32*gc -: 8];
            assign w_mix[RND_SIZE-1-32*gc  -: 8] = f_xtime(w_a0) ^ f_xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mix[RND_SIZE-9-32*gc  -: 8] = w_a0 ^ f_xtime(w_a1) ^ f_xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mix[RND_SIZE-17-32*gc -: 8] = w_a0 ^ w_a1 ^ f_xtime(w_a2) ^ f_xtime(w_a3) ^ w_a3;
            assign w_mix[RND_SIZE-25-32*gc -: 8] = f_xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ f_xtime(w_a3);
        end
    endgenerate

    assign w_last   = (r_cnt == r_nr);
    assign w_round  = (w_last ? w_shift : w_mix) ^ i_rnd_key;
    assign w_accept = i_in_valid & o_in_ready;

    always_comb begin
        case (i_key_len)
            2'd1:    w_nr = CNT_SIZE'(12);
            2'd2:    w_nr = CNT_SIZE'(14);
            default: w_nr = CNT_SIZE'(10);
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next = c_st_run;
            c_st_run:  if (w_last) w_next = c_st_done;
            c_st_done: begin
                if (w_accept)         w_next = c_st_run;
                else if (i_out_ready) w_next = c_st_idle;
            end
            default:   w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_nr    <= CNT_SIZE'(10);
            r_data  <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= i_rnd_text ^ i_rnd_key;
                r_nr   <= w_nr;
                r_tag  <= i_tag;
                r_cnt  <= CNT_SIZE'(1);
            end else if (r_state == c_st_run) begin
                r_data <= w_round;
                r_cnt  <= w_last ? '0 : r_cnt + CNT_SIZE'(1);
            end
        end
    end

    assign o_in_ready    = (r_state == c_st_idle) | ((r_state == c_st_done) & i_out_ready);
    assign o_rk_idx      = (r_state == c_st_run) ? r_cnt : '0;
    assign o_out_valid   = (r_state == c_st_done);
    assign o_busy        = (r_state != c_st_idle);
    assign o_cypher_text = r_data;
    assign o_tag         = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_iter_data_path
// Brief    : Directed bench for aes_iter_data_path using FIPS-197 C.1-C.3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_iter_data_path;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   i_key_len;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [127:0] i_rnd_text;
    logic [7:0]   i_tag;
    logic [3:0]   o_rk_idx;
    logic [127:0] i_rnd_key;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [127:0] o_cypher_text;
    logic [7:0]   o_tag;
    logic         o_busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    logic [127:0] rk [0:15];

    localparam logic [127:0] c_pt     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] c_key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] c_key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] c_key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_iter_data_path #(.RND_SIZE(128), .CNT_SIZE(4), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .i_key_len(i_key_len), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_rnd_text(i_rnd_text), .i_tag(i_tag),
        .o_rk_idx(o_rk_idx), .i_rnd_key(i_rnd_key), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_cypher_text(o_cypher_text), .o_tag(o_tag),
        .o_busy(o_busy));

    always #5 clk = ~clk;

    // Key-expansion store: combinational lookup by requested round index
    always_comb i_rnd_key = rk[o_rk_idx];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tbl[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic set_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one block, waits for the result and checks latency, ct and tag.
    // Retires it only when i_out_ready is already high.
    task automatic run_block(input string nm, input logic [1:0] kl, input logic [7:0] tg,
                             input logic [127:0] exp_ct, input int exp_lat, input bit flip_kl);
        int n;
        i_rnd_text = c_pt;
        i_key_len  = kl;
        i_tag      = tg;
        i_in_valid = 1'b1;
        chk({nm, "_in_ready"}, o_in_ready, 1'b1);
        @(negedge clk);
        i_in_valid = 1'b0;
        i_rnd_text = '1;
        i_tag      = 8'hee;
        n = 0;
        while (!o_out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (flip_kl && n == 3) i_key_len = 2'd2;
        end
        chk({nm, "_latency"}, 128'(n), 128'(exp_lat));
        chk({nm, "_ct"}, o_cypher_text, exp_ct);
        chk({nm, "_tag"}, o_tag, tg);
        if (i_out_ready) begin
            @(negedge clk);
            chk({nm, "_retired"}, o_out_valid, 1'b0);
        end
    endtask

    initial begin
        int  cyc, acc, outs, last, n;
        bit  ok, will_acc, seen;

        rst = 1'b1; i_key_len = 2'd0; i_in_valid = 1'b0; i_rnd_text = '0;
        i_tag = '0; i_out_ready = 1'b1;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", o_out_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_in_ready", o_in_ready, 1'b1);
        chk("rst_rk_idx", o_rk_idx, 4'd0);
        chk("rst_ct", o_cypher_text, 128'h0);
        chk("rst_tag", o_tag, 8'h0);

        set_key(c_key128, 4);
        run_block("aes128", 2'd0, 8'h11, c_ct128, 10, 1'b0);
        set_key(c_key192, 6);
        run_block("aes192", 2'd1, 8'h22, c_ct192, 12, 1'b0);
        set_key(c_key256, 8);
        run_block("aes256", 2'd2, 8'h33, c_ct256, 14, 1'b0);
        set_key(c_key128, 4);
        run_block("keylen3", 2'd3, 8'h44, c_ct128, 10, 1'b0);
        run_block("kl_flip", 2'd0, 8'h55, c_ct128, 10, 1'b1);

        // Backpressure: hold output for 20 cycles while a new block is offered
        i_out_ready = 1'b0;
        run_block("bp", 2'd0, 8'h66, c_ct128, 10, 1'b0);
        ok = 1'b1;
        i_in_valid = 1'b1;
        i_rnd_text = 128'hdeadbeef;
        repeat (20) begin
            @(negedge clk);
            if (!o_out_valid || o_cypher_text !== c_ct128 || o_tag !== 8'h66 || o_in_ready)
                ok = 1'b0;
        end
        chk("bp_stable", ok, 1'b1);
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_single_retire", o_out_valid, 1'b0);
        chk("bp_idle", o_busy, 1'b0);

        // Back-to-back: four AES-128 blocks with tags 1..4
        i_rnd_text = c_pt; i_key_len = 2'd0; i_tag = 8'd1; i_in_valid = 1'b1;
        cyc = 0; acc = 0; outs = 0; last = 0;
        while (outs < 4 && cyc < 100) begin
            if (o_out_valid) begin
                chk($sformatf("b2b_tag%0d", outs + 1), o_tag, 8'(outs + 1));
                chk($sformatf("b2b_ct%0d", outs + 1), o_cypher_text, c_ct128);
                if (outs > 0) chk($sformatf("b2b_gap%0d", outs + 1), 128'(cyc - last), 128'd11);
                last = cyc;
                outs++;
            end
            will_acc = o_in_ready && i_in_valid;
            @(negedge clk);
            cyc++;
            if (will_acc) begin
                acc++;
                if (acc == 4) i_in_valid = 1'b0;
                else          i_tag = 8'(acc + 1);
            end
        end
        chk("b2b_count", 128'(outs), 128'd4);
        @(negedge clk);

        // Reset in round 5 discards the block
        i_rnd_text = c_pt; i_key_len = 2'd0; i_tag = 8'h77; i_in_valid = 1'b1;
        @(negedge clk);
        i_in_valid = 1'b0;
        n = 0;
        while (o_rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_round5_reached", o_rk_idx, 4'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_out_valid", o_out_valid, 1'b0);
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_in_ready", o_in_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_out_valid) seen = 1'b1;
        end
        chk("mid_no_output", seen, 1'b0);
        run_block("after_rst", 2'd0, 8'h88, c_ct128, 10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
